// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: recovers the duty code from a PWM line with period 2^PWM_WIDTH.
// Each decoded period gives a one-cycle duty_valid; a malformed period gives a one-cycle period_err.
module pwm_duty_decoder #(
   parameter int PWM_WIDTH   = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pwm_in,
   output logic [PWM_WIDTH-1:0] duty,
   output logic                 duty_valid,
   output logic                 locked,
   output logic                 period_err
);
   localparam int CW = PWM_WIDTH + 1;
   localparam logic [CW-1:0] ONE = CW'(1);
   localparam logic [CW-1:0] P   = ONE << PWM_WIDTH;

   typedef enum logic {HUNT, MEASURE} state_t;

   state_t                 r_state, w_state_nx;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_prev;
   logic [CW-1:0]          r_period_cnt, r_high_cnt;
   logic [CW-1:0]          w_period_nx, w_high_nx;
   logic [PWM_WIDTH-1:0]   w_duty_nx;
   logic                   w_valid_nx, w_err_nx, w_locked_nx;
   logic                   w_s, w_rise, w_tout;

   assign w_s    = r_sync[SYNC_STAGES-1];
   assign w_rise = w_s & ~r_s_prev;
   assign w_tout = ~w_rise && (r_period_cnt == P);

   // A rise closes a period and wins over a same-cycle timeout.
   always_comb begin
      w_state_nx  = r_state;
      w_period_nx = (r_period_cnt == '1) ? r_period_cnt : r_period_cnt + ONE;
      w_high_nx   = (r_high_cnt == '1) ? r_high_cnt : r_high_cnt + CW'(w_s);
      w_duty_nx   = duty;
      w_valid_nx  = 1'b0;
      w_err_nx    = 1'b0;
      w_locked_nx = locked;
      if (w_rise) begin
         w_period_nx = ONE;
         w_high_nx   = ONE;
         w_state_nx  = MEASURE;
         if (r_state == MEASURE) begin
            if (r_period_cnt == P) begin
               w_duty_nx   = r_high_cnt[PWM_WIDTH-1:0];
               w_valid_nx  = 1'b1;
               w_locked_nx = 1'b1;
            end else begin
               w_err_nx    = 1'b1;
               w_locked_nx = 1'b0;
               w_state_nx  = HUNT;
            end
         end
      end else if (w_tout) begin
         w_period_nx = ONE;
         w_high_nx   = CW'(w_s);
         if (r_high_cnt == '0) begin
            w_duty_nx   = '0;
            w_valid_nx  = 1'b1;
            w_locked_nx = 1'b1;
            w_state_nx  = MEASURE;
         end else begin
            w_err_nx    = 1'b1;
            w_locked_nx = 1'b0;
            w_state_nx  = HUNT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= HUNT;
      else        r_state <= w_state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync       <= '0;
         r_s_prev     <= 1'b0;
         r_period_cnt <= '0;
         r_high_cnt   <= '0;
         duty         <= '0;
         duty_valid   <= 1'b0;
         locked       <= 1'b0;
         period_err   <= 1'b0;
      end else begin
         r_sync       <= {r_sync[SYNC_STAGES-2:0], pwm_in};
         r_s_prev     <= w_s;
         r_period_cnt <= w_period_nx;
         r_high_cnt   <= w_high_nx;
         duty         <= w_duty_nx;
         duty_valid   <= w_valid_nx;
         locked       <= w_locked_nx;
         period_err   <= w_err_nx;
      end
   end
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: directed PWM scenarios with a queue-based scoreboard.
// A bench generator drives pwm_in; a negedge monitor pops one expectation per reported event.
module tb_pwm_duty_decoder;
   localparam int W = 4;

   typedef struct {
      bit         err;
      logic [W-1:0] duty;
      bit         lk;
      int         gap;
      bit         rchk;
   } exp_t;

   logic         clk = 1'b0, rst_n = 1'b0, pwm_in = 1'b0, pwm_nx;
   logic [W-1:0] duty, prev_duty = '0;
   logic         duty_valid, locked, period_err;
   exp_t         q[$];
   exp_t         e;
   int n_tests = 0, n_fail = 0, cyc = 0, rise_cyc = -100, last_ev = 0, ev_count = 0, n0 = 0, prev = 5;
   int gcnt = 15, cur_mode = 0, cur_duty = 0, cur_per = 16, nxt_mode = 0, nxt_duty = 5, nxt_per = 16;
   int sweep[3] = '{1, 8, 15};

   pwm_duty_decoder #(.PWM_WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .duty(duty),
      .duty_valid(duty_valid), .locked(locked), .period_err(period_err)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Generator: free-running counter, high while counter < duty; settings change only at a wrap.
   // mode 0 = PWM, 1 = held low, 2 = held high.
   initial forever begin
      @(posedge clk);
      #1;
      if (gcnt >= cur_per - 1) begin
         gcnt = 0;
         cur_mode = nxt_mode;
         cur_duty = nxt_duty;
         cur_per = nxt_per;
      end else gcnt++;
      pwm_nx = (cur_mode == 0) ? (gcnt < cur_duty) : (cur_mode == 2);
      if (pwm_nx && !pwm_in) rise_cyc = cyc + 1;
      pwm_in = pwm_nx;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (duty_valid || period_err) begin
         chk("exclusive", int'(duty_valid && period_err), 0);
         ev_count++;
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got valid=%0d err=%0d duty=%0d, expected no event (cycle %0d)",
                     duty_valid, period_err, duty, cyc);
         end else begin
            e = q.pop_front();
            chk("kind_err", int'(period_err), int'(e.err));
            chk("duty", int'(duty), int'(e.duty));
            chk("locked", int'(locked), int'(e.lk));
            if (e.gap != 0) chk("gap", cyc - last_ev, e.gap);
            if (e.rchk) chk("rise_latency", cyc - rise_cyc, 2);
         end
         last_ev = cyc;
      end else if (rst_n) chk("duty_hold", int'(duty), int'(prev_duty));
      prev_duty = duty;
   end

   task automatic push(input bit err, input int d, input bit lk, input int gap, input bit rchk);
      exp_t x;
      x.err = err;
      x.duty = W'(d);
      x.lk = lk;
      x.gap = gap;
      x.rchk = rchk;
      q.push_back(x);
   endtask

   task automatic push_n(input bit err, input int d, input bit lk, input int n, input int gap0,
                         input int gap, input bit rchk);
      for (int i = 0; i < n; i++) push(err, d, lk, (i == 0) ? gap0 : gap, rchk);
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 400) begin
         @(posedge clk);
         t++;
      end
      if (q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expected events still pending, expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic wait_phase(input int v);
      int t = 0;
      do begin
         @(posedge clk);
         #2;
         t++;
      end while (gcnt != v && t < 64);
   endtask

   task automatic chk_outs(input string name, input int d, input int lk);
      chk({name, "_duty"}, int'(duty), d);
      chk({name, "_valid"}, int'(duty_valid), 0);
      chk({name, "_locked"}, int'(locked), lk);
      chk({name, "_err"}, int'(period_err), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2 chk_outs("reset", 0, 0);
      // Duty 5: first rise is discarded, then a report every 16 cycles.
      wait_phase(8);
      push_n(0, 5, 1, 4, 0, 16, 1);
      rst_n = 1'b1;
      n0 = ev_count;
      wait_phase(4);
      chk("no_first_report", ev_count - n0, 0);
      drain();
      // Sweep: the period closed right after a change still carries the old code.
      foreach (sweep[i]) begin
         nxt_duty = sweep[i];
         push(0, prev, 1, 16, 1);
         push_n(0, sweep[i], 1, 3, 16, 16, 1);
         drain();
         prev = sweep[i];
      end
      // Stuck high while locked at 7, then restore.
      nxt_duty = 7;
      push(0, 15, 1, 16, 1);
      push_n(0, 7, 1, 2, 16, 16, 1);
      drain();
      nxt_mode = 2;
      push(0, 7, 1, 16, 1);
      push_n(1, 7, 0, 3, 16, 16, 0);
      drain();
      nxt_mode = 0;
      push(1, 7, 0, 16, 0);
      push(0, 7, 1, 32, 1);
      push(0, 7, 1, 16, 1);
      drain();
      chk("relocked", int'(locked), 1);
      // Line held low after reset: duty 0 every 16 cycles, never an error.
      rst_n = 1'b0;
      #1 chk_outs("reset2", 0, 0);
      nxt_mode = 1;
      repeat (20) @(posedge clk);
      push_n(0, 0, 1, 4, 0, 16, 0);
      rst_n = 1'b1;
      drain();
      chk("low_locked", int'(locked), 1);
      // Period 12: every measured period is too short.
      rst_n = 1'b0;
      nxt_mode = 0;
      nxt_per = 12;
      nxt_duty = 4;
      repeat (20) @(posedge clk);
      wait_phase(8);
      push_n(1, 0, 0, 3, 0, 24, 1);
      rst_n = 1'b1;
      drain();
      chk("short_unlocked", int'(locked), 0);
      // Mid-period reset while locked at 9.
      rst_n = 1'b0;
      nxt_per = 16;
      nxt_duty = 9;
      repeat (20) @(posedge clk);
      wait_phase(12);
      push_n(0, 9, 1, 3, 0, 16, 1);
      rst_n = 1'b1;
      drain();
      wait_phase(10);
      chk("pre_reset_duty", int'(duty), 9);
      chk("pre_reset_locked", int'(locked), 1);
      rst_n = 1'b0;
      #1 chk_outs("async_reset", 0, 0);
      wait_phase(13);
      push_n(0, 9, 1, 2, 0, 16, 1);
      rst_n = 1'b1;
      drain();
      repeat (4) @(posedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
